// File: rtl/pipe_pkg.sv
// Shared types and default widths for the inter-stage pipeline latch.
package pipe_pkg;

    // Default payload width (pc+4, alu result, rdat2, control bits ...)
    localparam int PIPE_DATA_W  = 64;
    // Default memory-request sideband width, e.g. {dREN, dWEN}
    localparam int PIPE_REQ_W   = 2;
    // Default stall counter width
    localparam int PIPE_COUNT_W = 16;

    // Occupancy of the latch, mirroring the (main, skid) valid bits:
    //   EMPTY = main 0, skid 0
    //   ONE   = main 1, skid 0
    //   FULL  = main 1, skid 1
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } latch_state_t;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of the latch: valid bit, payload and memory-request bits.
// Priority is clear > load > drop_req. A cleared slot holds all zeros, so an
// empty slot always presents zero payload and zero request bits.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int REQ_W  = PIPE_REQ_W
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic              i_drop_req,
    input  logic [DATA_W-1:0] i_data,
    input  logic [REQ_W-1:0]  i_req,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [REQ_W-1:0]  o_req
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [REQ_W-1:0]  r_req;

    // Slot register: clear empties it, load fills it, drop_req squashes only the request bits.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_req   <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_req   <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_req   <= i_req;
        end else if (i_drop_req) begin
            r_req   <= '0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_req   = r_req;

endmodule

// File: rtl/pipe_skid_latch.sv
// Inter-stage pipeline latch with a valid/ready handshake and a main+skid
// buffer so that in_ready comes straight from a flop.
//
// Handshake: an entry moves across a port only in a cycle where both valid
// and ready are high at the rising edge of CLK (in_fire additionally requires
// !flush). valid must not depend combinationally on ready; in_ready is a
// register, so there is no combinational path from out_ready to in_ready.
//
// The main slot drives the outputs. The skid slot catches one entry that was
// accepted while the main slot was stalled. While the main entry is stalled,
// dhit squashes its request bits so the dcache request is not reissued.
module pipe_skid_latch
    import pipe_pkg::*;
#(
    parameter int DATA_W  = PIPE_DATA_W,
    parameter int REQ_W   = PIPE_REQ_W,
    parameter int COUNT_W = PIPE_COUNT_W
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [REQ_W-1:0]   in_req,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [REQ_W-1:0]   out_req,
    input  logic               dhit,
    input  logic               clr_cnt,
    output logic [COUNT_W-1:0] stall_cnt,
    output latch_state_t       o_dbg_state
);

    localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    latch_state_t       r_state;
    logic               r_in_ready;
    logic [COUNT_W-1:0] r_stall_cnt;

    latch_state_t       w_state_nxt;
    logic               w_in_fire;
    logic               w_out_fire;
    logic               w_stalled;
    logic               w_main_load;
    logic               w_main_clear;
    logic               w_main_from_skid;
    logic               w_main_drop_req;
    logic               w_skid_load;
    logic               w_skid_clear;

    logic               w_main_valid;
    logic [DATA_W-1:0]  w_main_data;
    logic [REQ_W-1:0]   w_main_req;
    logic               w_skid_valid;
    logic [DATA_W-1:0]  w_skid_data;
    logic [REQ_W-1:0]   w_skid_req;
    logic [DATA_W-1:0]  w_main_src_data;
    logic [REQ_W-1:0]   w_main_src_req;

    assign w_in_fire  = in_valid & r_in_ready & ~flush;
    assign w_out_fire = w_main_valid & out_ready;
    assign w_stalled  = w_main_valid & ~out_ready;

    // A stalled main entry cannot be loaded or cleared this cycle (except by
    // flush), so squashing its request bits never races a reload.
    assign w_main_drop_req = w_stalled & dhit & ~flush;

    // Refill of main comes from the skid when draining FULL, else from the input.
    assign w_main_src_data = w_main_from_skid ? w_skid_data : in_data;
    assign w_main_src_req  = w_main_from_skid ? w_skid_req  : in_req;

    // Slot control and next occupancy; flush overrides every transfer.
    always_comb begin
        w_state_nxt      = r_state;
        w_main_load      = 1'b0;
        w_main_clear     = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        w_skid_clear     = 1'b0;
        if (flush) begin
            w_main_clear = 1'b1;
            w_skid_clear = 1'b1;
            w_state_nxt  = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in_fire) begin
                        w_main_load = 1'b1;
                        w_state_nxt = ONE;
                    end
                end
                ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_load = 1'b1;
                    end else if (w_out_fire) begin
                        w_main_clear = 1'b1;
                        w_state_nxt  = EMPTY;
                    end else if (w_in_fire) begin
                        w_skid_load = 1'b1;
                        w_state_nxt = FULL;
                    end
                end
                FULL: begin
                    if (w_out_fire) begin
                        w_main_load      = 1'b1;
                        w_main_from_skid = 1'b1;
                        w_skid_clear     = 1'b1;
                        w_state_nxt      = ONE;
                    end
                end
                default: begin
                    w_main_clear = 1'b1;
                    w_skid_clear = 1'b1;
                    w_state_nxt  = EMPTY;
                end
            endcase
        end
    end

    // Occupancy FSM with registered in_ready: ready next cycle unless the skid will be occupied.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != FULL);
        end
    end

    // Saturating count of stalled-output cycles; clear wins, flush leaves it alone.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_stall_cnt <= '0;
        end else if (clr_cnt) begin
            r_stall_cnt <= '0;
        end else if (w_stalled && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
        end
    end

    pipe_slot #(
        .DATA_W (DATA_W),
        .REQ_W  (REQ_W)
    ) u_main (
        .CLK        (CLK),
        .nRST       (nRST),
        .i_load     (w_main_load),
        .i_clear    (w_main_clear),
        .i_drop_req (w_main_drop_req),
        .i_data     (w_main_src_data),
        .i_req      (w_main_src_req),
        .o_valid    (w_main_valid),
        .o_data     (w_main_data),
        .o_req      (w_main_req)
    );

    // The skid never sees dhit: its request has not been presented yet.
    pipe_slot #(
        .DATA_W (DATA_W),
        .REQ_W  (REQ_W)
    ) u_skid (
        .CLK        (CLK),
        .nRST       (nRST),
        .i_load     (w_skid_load),
        .i_clear    (w_skid_clear),
        .i_drop_req (1'b0),
        .i_data     (in_data),
        .i_req      (in_req),
        .o_valid    (w_skid_valid),
        .o_data     (w_skid_data),
        .o_req      (w_skid_req)
    );

    assign in_ready    = r_in_ready;
    assign out_valid   = w_main_valid;
    assign out_data    = w_main_data;
    assign out_req     = w_main_req;
    assign stall_cnt   = r_stall_cnt;
    assign o_dbg_state = r_state;

endmodule
